// File: rtl/lsu_trigger_pipe_pkg.sv
// Shared LSU trigger types: stage payload, trigger count and the pairwise chain resolver.
package swerv_types;

    localparam int unsigned NUM_TRIG = 4;
    localparam int unsigned NUM_PAIR = NUM_TRIG / 2;

    typedef struct packed {
        logic [NUM_TRIG-1:0] match;
        logic                valid;
    } lsu_trig_stage_t;

    // A chained pair only fires when both halves matched; then both bits report the hit.
    function automatic logic [NUM_TRIG-1:0] trig_chain_resolve(
        input logic [NUM_TRIG-1:0] m,
        input logic [NUM_PAIR-1:0] chain
    );
        logic [NUM_TRIG-1:0] r;
        logic                both;
        r = m;
        for (int unsigned k = 0; k < NUM_PAIR; k++) begin
            both = m[2*k] & m[2*k+1];
            if (chain[k]) begin
                r[2*k]   = both;
                r[2*k+1] = both;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lsu_trigger_pipe_hitcnt.sv
// Single saturating hit counter; clear wins over increment.
module lsu_trig_hitcnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lsu_trigger_pipe.sv
// LSU trigger dc3->dc4->dc5 pipe with pairwise chaining, freeze/flush and sticky hit status.
// Per-trigger saturating hit counters are built only when LSU_TRIGGER_CNT_EN is defined.
module lsu_trigger_pipe #(
    parameter int unsigned NUM_TRIG = swerv_types::NUM_TRIG
`ifdef LSU_TRIGGER_CNT_EN
    ,
    parameter int unsigned CNT_W    = 8
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_TRIG-1:0]       lsu_trigger_match_dc3,
    input  logic                      lsu_pkt_valid_dc3,
    input  logic [NUM_TRIG/2-1:0]     trigger_chain,
    input  logic                      lsu_freeze_dc3,
    input  logic                      dec_tlu_flush_lower_wb,
    input  logic [NUM_TRIG-1:0]       trig_status_clr,
    output logic [NUM_TRIG-1:0]       lsu_trigger_match_dc5,
`ifdef LSU_TRIGGER_CNT_EN
    output logic [NUM_TRIG*CNT_W-1:0] lsu_trigger_hit_cnt,
`endif
    output logic [NUM_TRIG-1:0]       lsu_trigger_hit_status
);

    import swerv_types::*;

    logic [NUM_TRIG-1:0] m3_c;
    logic [NUM_TRIG-1:0] m3_chained_c;
    logic [NUM_TRIG-1:0] status_set_c;
    lsu_trig_stage_t     dc4;

    assign m3_c         = lsu_trigger_match_dc3 & {NUM_TRIG{lsu_pkt_valid_dc3}};
    assign m3_chained_c = trig_chain_resolve(m3_c, trigger_chain);
    assign status_set_c = lsu_freeze_dc3 ? '0 : lsu_trigger_match_dc5;

    // dc4 capture: flush kills the stage even while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            dc4 <= '0;
        end else if (dec_tlu_flush_lower_wb) begin
            dc4 <= '0;
        end else if (!lsu_freeze_dc3) begin
            dc4.match <= m3_chained_c;
            dc4.valid <= lsu_pkt_valid_dc3;
        end
    end

    // dc5 is never flushed; it only holds on freeze.
    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_trigger_match_dc5 <= '0;
        end else if (!lsu_freeze_dc3) begin
            lsu_trigger_match_dc5 <= dc4.match & {NUM_TRIG{dc4.valid}};
        end
    end

    // Sticky status: clear always honoured, set suppressed while frozen, set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_trigger_hit_status <= '0;
        end else begin
            lsu_trigger_hit_status <= (lsu_trigger_hit_status & ~trig_status_clr) | status_set_c;
        end
    end

`ifdef LSU_TRIGGER_CNT_EN
    for (genvar i = 0; i < NUM_TRIG; i++) begin : g_hitcnt
        lsu_trig_hitcnt #(
            .CNT_W (CNT_W)
        ) u_hitcnt (
            .clk (clk),
            .rst (rst),
            .inc (status_set_c[i]),
            .clr (trig_status_clr[i]),
            .cnt (lsu_trigger_hit_cnt[i*CNT_W +: CNT_W])
        );
    end
`endif

endmodule
